// File: rtl/riscv_pkg.sv
// Shared RV32 load/store encodings, LSU FSM states and default sizing.
package riscv_pkg;

    localparam int ADDR_W_DEF = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        RESP
    } lsu_state_t;

    // Illegal encoding or misaligned address for the given access.
    function automatic logic lsu_bad(
        input logic       store,
        input logic [2:0] op,
        input logic [1:0] a
    );
        logic bad;
        bad = 1'b1;
        case (op)
            F3_B:  bad = 1'b0;
            F3_H:  bad = a[0];
            F3_W:  bad = (a != 2'b00);
            F3_BU: bad = store;
            F3_HU: bad = store | a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte/half lane extraction for loads and lane merge for sub-word stores.
module lsu_lane_fmt
    import riscv_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  b;
    logic [15:0] h;

    assign bsh = {addr_lo, 3'b000};
    assign hsh = {addr_lo[1], 4'b0000};
    assign b   = rdata[bsh +: 8];
    assign h   = rdata[hsh +: 16];

    always_comb begin
        load_data = rdata;
        case (op)
            F3_B:  load_data = {{24{b[7]}}, b};
            F3_BU: load_data = {24'h0, b};
            F3_H:  load_data = {{16{h[15]}}, h};
            F3_HU: load_data = {16'h0, h};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        merge_data = rdata;
        case (op)
            F3_B:    merge_data[bsh +: 8]  = wdata[7:0];
            F3_H:    merge_data[hsh +: 16] = wdata[15:0];
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit: single-port word memory, RMW for SB/SH.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_ren,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wen,
    output logic [31:0]       mem_wdata
);

    lsu_state_t        state;
    lsu_state_t        next;
    logic [2:0]        op_q;
    logic              store_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              accept;
    logic              bad;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;
    logic              unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_W];

    assign accept = req_valid & (state == IDLE);
    assign bad    = lsu_bad(req_store, req_op, req_addr[1:0]);

    lsu_lane_fmt u_fmt (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (bad)
                        next = RESP;
                    else if (req_store && req_op == F3_W)
                        next = WR;
                    else
                        next = RD;
                end
            end
            RD:      next = RD_WAIT;
            RD_WAIT: next = store_q ? WR : RESP;
            WR:      next = RESP;
            RESP:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= 3'b000;
            store_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state <= next;
            if (accept) begin
                op_q    <= req_op;
                store_q <= req_store;
                addr_q  <= req_addr[ADDR_W-1:0];
                wdata_q <= req_wdata;
                err_q   <= bad;
                if (bad)
                    rdata_q <= 32'h0;
            end
            // Sub-word stores park the merged word in wdata_q for WR.
            if (state == RD_WAIT) begin
                if (store_q)
                    wdata_q <= merge_data;
                else
                    rdata_q <= load_data;
            end
            if (state == WR)
                rdata_q <= 32'h0;
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) & err_q;
    assign resp_rdata = rdata_q;
    assign mem_ren    = (state == RD);
    assign mem_wen    = (state == WR);
    assign mem_addr   = addr_q[ADDR_W-1:2];
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read word memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [5:0]  mem_addr;
    logic        mem_ren;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_wen;
    logic [31:0] mem_wdata;

    logic [31:0] mem [64];
    logic        poke_en = 1'b0;
    logic [5:0]  poke_idx = 6'd0;
    logic [31:0] poke_val = 32'h0;
    int          wen_total = 0;
    int          resp_total = 0;
    int          both_cnt = 0;

    int          checks = 0;
    int          failures = 0;
    int          lat;
    int          wen_at;
    int          wen_n;
    int          ren_n;
    logic [31:0] r_data;
    logic        r_err;
    int          w0;
    int          r0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_ren    (mem_ren),
        .mem_rdata  (mem_rdata),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata)
    );

    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_addr];
        if (mem_wen) wen_total <= wen_total + 1;
        if (resp_valid) resp_total <= resp_total + 1;
        if (mem_wen && mem_ren) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en = 1'b1;
        poke_idx = idx;
        poke_val = val;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Called at the first negedge after the accept edge (cycle T+1).
    task automatic wait_resp();
        lat = -1;
        wen_at = -1;
        wen_n = 0;
        ren_n = 0;
        r_data = 32'hx;
        r_err = 1'bx;
        for (int n = 1; n <= 10; n++) begin
            if (mem_wen) begin
                wen_at = n;
                wen_n++;
            end
            if (mem_ren) ren_n++;
            if (resp_valid) begin
                lat = n;
                r_data = resp_rdata;
                r_err = resp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd);
        int k;
        @(negedge clk);
        req_valid = 1'b1;
        req_store = st;
        req_op = op;
        req_addr = addr;
        req_wdata = wd;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_strobes", {30'h0, mem_ren, mem_wen}, 32'h0);

        poke(6'd3, 32'h8899AABB);
        issue(1'b0, 3'b000, 32'h0E, 32'h0);
        chk("lb_lat", lat, 3);
        chk("lb_data", r_data, 32'hFFFFFF99);
        chk("lb_err", {31'h0, r_err}, 32'h0);
        issue(1'b0, 3'b100, 32'h0E, 32'h0);
        chk("lbu_data", r_data, 32'h00000099);
        chk("rdata_hold", resp_rdata, 32'h00000099);

        issue(1'b1, 3'b000, 32'h0D, 32'h12345677);
        chk("sb_lat", lat, 4);
        chk("sb_wen_at", wen_at, 3);
        chk("sb_wen_n", wen_n, 1);
        chk("sb_rdata", r_data, 32'h0);
        chk("sb_word", mem[3], 32'h889977BB);

        poke(6'd3, 32'h8899AABB);
        issue(1'b1, 3'b001, 32'h0E, 32'h0000CAFE);
        chk("sh_lat", lat, 4);
        chk("sh_word", mem[3], 32'hCAFEAABB);
        issue(1'b0, 3'b001, 32'h0E, 32'h0);
        chk("lh_data", r_data, 32'hFFFFCAFE);
        issue(1'b0, 3'b101, 32'h0E, 32'h0);
        chk("lhu_data", r_data, 32'h0000CAFE);
        issue(1'b0, 3'b010, 32'h0C, 32'h0);
        chk("lw_data", r_data, 32'hCAFEAABB);
        issue(1'b0, 3'b000, 32'h0C, 32'h0);
        chk("lb_lane0", r_data, 32'hFFFFFFBB);

        issue(1'b0, 3'b010, 32'h06, 32'h0);
        chk("lw_mis_lat", lat, 1);
        chk("lw_mis_err", {31'h0, r_err}, 32'h1);
        chk("lw_mis_strobes", ren_n + wen_n, 0);
        chk("lw_mis_rdata", r_data, 32'h0);
        issue(1'b1, 3'b001, 32'h03, 32'hFFFF);
        chk("sh_mis_lat", lat, 1);
        chk("sh_mis_err", {31'h0, r_err}, 32'h1);
        chk("sh_mis_strobes", ren_n + wen_n, 0);
        issue(1'b0, 3'b011, 32'h0C, 32'h0);
        chk("ld_op3_err", {31'h0, r_err}, 32'h1);
        issue(1'b1, 3'b100, 32'h0C, 32'h0);
        chk("st_op4_err", {31'h0, r_err}, 32'h1);
        chk("st_op4_strobes", ren_n + wen_n, 0);
        chk("err_word", mem[3], 32'hCAFEAABB);
        @(negedge clk);
        chk("err_idle", {31'h0, resp_err}, 32'h0);

        poke(6'd5, 32'h11223344);
        w0 = wen_total;
        r0 = resp_total;
        @(negedge clk);
        req_valid = 1'b1;
        req_store = 1'b1;
        req_op = 3'b000;
        req_addr = 32'h14;
        req_wdata = 32'hAA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        repeat (4) @(negedge clk);
        chk("abort_wen", wen_total, w0);
        chk("abort_resp", resp_total, r0);
        chk("abort_word", mem[5], 32'h11223344);

        @(negedge clk);
        req_valid = 1'b1;
        req_store = 1'b1;
        req_op = 3'b010;
        req_addr = 32'h104;
        req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req_store = 1'b0;
        req_wdata = 32'h0;
        chk("b2b_busy1", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("b2b_resp", {31'h0, resp_valid}, 32'h1);
        chk("b2b_busy2", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("b2b_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp();
        chk("b2b_lw_lat", lat, 3);
        chk("b2b_lw_data", r_data, 32'hDEADBEEF);
        chk("wrap_word1", mem[1], 32'hDEADBEEF);
        chk("ren_wen_excl", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: byte-address bits decoded (256 B = 64 words); higher bits ignored.
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  request present; req_ready  out  1  unit accepts request this cycle.
REQ-005 req_store  in  1  1 = store, 0 = load; req_op  in  3  RV32 funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 req_addr  in  32  byte address; req_wdata  in  32  store data (rs2).
REQ-007 resp_valid  out  1  one-cycle completion pulse; resp_rdata  out  32  load result; resp_err  out  1  misaligned or illegal op.
REQ-008 mem_addr  out  ADDR_W-2  word index; mem_ren  out  1  word read strobe; mem_rdata  in  32  read data, valid cycle after mem_ren.
REQ-009 mem_wen  out  1  word write strobe; mem_wdata  out  32  full word written.

Function
REQ-010 SHALL implement FSM states IDLE, RD, RD_WAIT, WR, RESP; req_ready=1 only in IDLE.
REQ-011 Accept (cycle T) = req_valid & req_ready; SHALL register op, store flag, addr[ADDR_W-1:0], wdata at T.
REQ-012 Error check at T: H/HU/SH with addr[0]=1, W/SW with addr[1:0]!=0, load op 011/110/111, store op >=011 SHALL go IDLE->RESP with no memory strobe.
REQ-013 Load: T+1 RD (mem_ren=1), T+2 RD_WAIT (format mem_rdata into resp_rdata reg), T+3 RESP.
REQ-014 SW: T+1 WR (mem_wen=1, mem_wdata=wdata), T+2 RESP.
REQ-015 SB/SH: T+1 RD, T+2 RD_WAIT (merge lane into read word), T+3 WR writes merged word, T+4 RESP.
REQ-016 mem_addr SHALL equal registered addr[ADDR_W-1:2] in RD and WR; mem_ren/mem_wen SHALL be 1 only in RD/WR respectively and never together.
REQ-017 Byte lane = addr[1:0]; half lane = addr[1]; LB/LH sign-extend from lane MSB, LBU/LHU zero-extend.
REQ-018 SB merge replaces bits [8*k+7:8*k] with wdata[7:0]; SH replaces [16*h+15:16*h] with wdata[15:0]; other bytes preserved.
REQ-019 In RESP: resp_valid=1 for exactly one cycle, then IDLE; no backpressure on response.
REQ-020 resp_rdata SHALL hold its value until next load completes; SHALL be 0 on stores and on errors.
REQ-021 resp_err SHALL be valid only with resp_valid, 0 otherwise.
REQ-022 req_valid while req_ready=0 SHALL be ignored; upstream holds the request.
REQ-023 Addresses wrap modulo 2^ADDR_W.

Reset
REQ-024 rst high at a rising edge SHALL force IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_ren=0, mem_wen=0 next cycle.
REQ-025 Reset mid-operation SHALL abort; a pending RMW write SHALL NOT be issued; no response SHALL be produced.

Structure
REQ-026 Shared package riscv_pkg SHALL hold funct3 load/store encodings, FSM state enum, default ADDR_W.
REQ-027 Lane extract/merge logic SHALL be one combinational sub-module lsu_lane_fmt; FSM and registers stay in load_store_unit.
REQ-028 Outputs mem_* and resp_* SHALL be registered or decoded from registered state only.

Verification
REQ-029 Mem word 3 = 0x8899AABB; LB addr 0x0E -> T+3 resp_rdata=0xFFFFFF99, resp_err=0; LBU same -> 0x00000099.
REQ-030 Word 3 = 0x8899AABB; SB addr 0x0D wdata 0x12345677 -> one mem_wen at T+3, word 3 = 0x889977BB, resp_valid at T+4.
REQ-031 SH addr 0x0E wdata 0xCAFE, then LH addr 0x0E -> word 3 = 0xCAFEAABB, resp_rdata=0xFFFFCAFE.
REQ-032 LW addr 0x06 and SH addr 0x03 -> resp_valid at T+1 with resp_err=1, no mem_ren/mem_wen, memory unchanged.
REQ-033 SB started, rst asserted at T+2 -> no mem_wen, no resp_valid, req_ready=1 cycle after rst deasserts, word unchanged.
REQ-034 Back-to-back requests with req_valid held high -> second accepted only in cycle after RESP; SW addr 0x104 (ADDR_W=8) writes word 1.
